// File: rtl/misr_pkg.sv
// Shared MISR engine types: control-FSM state encoding.
package misr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } misr_state_e;

endpackage

// File: rtl/misr_core.sv
// Signature register with Galois-style feedback and NIN parallel inputs.
// One-cycle update on en; load (seed) has priority over en; no backpressure of its own.
module misr_core
  import misr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h1021,
  parameter int               NIN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic [NIN-1:0]   din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] din_ext;
  logic [WIDTH-1:0] taps;
  logic             fb;

  assign fb      = q_q[WIDTH-1];
  assign din_ext = WIDTH'(din);
  // Stage 0 always takes feedback regardless of POLY[0].
  assign taps    = {POLY[WIDTH-1:1], 1'b1};
  assign q_d     = {q_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{fb}} & taps) ^ din_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (load) begin
      q_q <= seed;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/misr_engine.sv
// MISR compaction engine: compacts len beats into sig, one-cycle update per beat; in_ready only in RUN.
// Build option MISR_ENGINE_CMP_EN adds a golden-signature compare (golden in, pass out).
module misr_engine
  import misr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h1021,
  parameter int               NIN   = 1,
  parameter logic [WIDTH-1:0] SEED  = '0,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [NIN-1:0]   din,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
`ifdef MISR_ENGINE_CMP_EN
  input  logic [WIDTH-1:0] golden,
  output logic             pass,
`endif
  output logic [WIDTH-1:0] sig
);

  misr_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load;
  logic             accept;

  assign accept = in_valid && (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = len;
          state_d = (len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here; only accepted beats advance the run.
        if (accept) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  misr_core #(
    .WIDTH(WIDTH),
    .POLY (POLY),
    .NIN  (NIN)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .load(load),
    .seed(SEED),
    .en  (accept),
    .din (din),
    .q   (sig)
  );

  assign in_ready = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

`ifdef MISR_ENGINE_CMP_EN
  assign pass = (state_q == ST_DONE) && (sig == golden);
`endif

endmodule

// File: tb/tb_misr_engine.sv
// Scoreboarded bench for misr_engine (WIDTH=4, POLY=4'b0011, NIN=1, SEED=0).
// Define MISR_ENGINE_CMP_EN to also exercise golden/pass.
module tb_misr_engine;

  localparam int W     = 4;
  localparam int NIN   = 1;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic [NIN-1:0]   din;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [W-1:0]     sig;
`ifdef MISR_ENGINE_CMP_EN
  logic [W-1:0]     golden;
  logic             pass;
`endif

  typedef struct packed {
    logic [W-1:0] sig;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  misr_engine #(
    .WIDTH(W),
    .POLY (4'b0011),
    .NIN  (NIN),
    .SEED (4'b0000),
    .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .in_valid(in_valid),
    .din     (din),
    .in_ready(in_ready),
    .busy    (busy),
    .done    (done),
`ifdef MISR_ENGINE_CMP_EN
    .golden  (golden),
    .pass    (pass),
`endif
    .sig     (sig)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: an accepted beat (sampled mid-cycle) must show its expected sig/done one cycle later.
  initial begin : monitor
    logic pend;
    exp_t e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_sig", 32'(sig), 32'(e.sig));
          chk("beat_done", 32'(done), 32'(e.done));
        end
      end
`ifdef MISR_ENGINE_CMP_EN
      if (busy) chk("pass_in_run", 32'(pass), 0);
`endif
      pend = in_valid && in_ready && !rst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic d, input logic [W-1:0] es, input logic ed);
    in_valid = 1'b1;
    din      = d;
    exp_q.push_back('{sig: es, done: ed});
    tick();
    in_valid = 1'b0;
    din      = '0;
  endtask

  task automatic run_basic();
    beat(1'b1, 4'b0001, 1'b0);
    beat(1'b0, 4'b0010, 1'b0);
    beat(1'b0, 4'b0100, 1'b0);
    beat(1'b0, 4'b1000, 1'b0);
    beat(1'b0, 4'b0011, 1'b1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; din = '0;
`ifdef MISR_ENGINE_CMP_EN
    golden = 4'b0011;
`endif
    repeat (3) tick();
    chk("rst_sig", 32'(sig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    tick();

    // Basic 5-beat run, feedback kicks in on the last beat.
    do_start(8'd5);
    chk("run_busy", 32'(busy), 1);
    chk("run_in_ready", 32'(in_ready), 1);
    chk("run_seed", 32'(sig), 0);
    run_basic();
    chk("basic_done", 32'(done), 1);
    chk("basic_busy", 32'(busy), 0);
`ifdef MISR_ENGINE_CMP_EN
    chk("pass_match", 32'(pass), 1);
    golden = 4'b0000;
    #1;
    chk("pass_mismatch", 32'(pass), 0);
`endif
    in_valid = 1'b1; din = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0; din = '0;
    chk("done_hold_sig", 32'(sig), 32'(4'b0011));
    chk("done_hold", 32'(done), 1);

    // len=0 goes straight to DONE with sig reloaded from SEED.
    do_start(8'd0);
    chk("len0_done", 32'(done), 1);
    chk("len0_sig", 32'(sig), 0);
    chk("len0_in_ready", 32'(in_ready), 0);
    tick();
    chk("len0_in_ready2", 32'(in_ready), 0);
    chk("len0_done2", 32'(done), 1);

    // Gapped input: count and sig only move on accepted beats.
    do_start(8'd3);
    beat(1'b1, 4'b0001, 1'b0);
    din = 1'b1;
    tick();
    chk("gap1_sig", 32'(sig), 32'(4'b0001));
    chk("gap1_busy", 32'(busy), 1);
    beat(1'b1, 4'b0011, 1'b0);
    tick();
    chk("gap2_sig", 32'(sig), 32'(4'b0011));
    chk("gap2_done", 32'(done), 0);
    beat(1'b1, 4'b0111, 1'b1);

    // Reset mid-run abandons it; a start right after works.
    do_start(8'd5);
    beat(1'b1, 4'b0001, 1'b0);
    beat(1'b1, 4'b0011, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_sig", 32'(sig), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    do_start(8'd5);
    chk("after_rst_busy", 32'(busy), 1);
    run_basic();

    // start during RUN is ignored; start in DONE begins a new run from SEED.
    do_start(8'd2);
    start = 1'b1; len = 8'd0;
    beat(1'b1, 4'b0001, 1'b0);
    start = 1'b0;
    chk("start_in_run_busy", 32'(busy), 1);
    beat(1'b0, 4'b0010, 1'b1);
    do_start(8'd1);
    chk("restart_sig", 32'(sig), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_done", 32'(done), 0);
    beat(1'b1, 4'b0001, 1'b1);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/misr_engine.md
MISR_ENGINE -- requirements
Module: misr_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signature register width (2..64).
REQ-002 SHALL have parameter POLY, default 16'h1021, WIDTH-bit feedback taps; bit k set XORs the feedback into stage k; bit 0 is ignored because stage 0 always takes feedback.
REQ-003 SHALL have parameter NIN, default 1, number of parallel data inputs (1..WIDTH); NIN=1 gives serial-input (SISR) mode.
REQ-004 SHALL have parameter SEED, default 0, WIDTH-bit value loaded on start.
REQ-005 SHALL have parameter CNT_W, default 16, width of the beat counter.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-008 SHALL have port rst  in  1  synchronous active-high reset.
REQ-009 SHALL have port start  in  1  begin a compaction run.
REQ-010 SHALL have port len  in  CNT_W  number of beats to compact, sampled on accepted start.
REQ-011 SHALL have port in_valid  in  1  din is valid.
REQ-012 SHALL have port din  in  NIN  data beat.
REQ-013 SHALL have port in_ready  out  1  high only in RUN.
REQ-014 SHALL have port busy  out  1  high in RUN.
REQ-015 SHALL have port done  out  1  high in DONE, held until the next start or reset.
REQ-016 SHALL have port sig  out  WIDTH  current register contents.

Function
REQ-017 SHALL use FSM states IDLE, RUN, DONE.
REQ-018 SHALL, in IDLE or DONE on start=1, load sig<=SEED and cnt<=len, then go to RUN if len!=0, else to DONE.
REQ-019 SHALL ignore start while in RUN.
REQ-020 SHALL define a beat as accepted when in_valid && in_ready; only accepted beats update sig and decrement cnt.
REQ-021 SHALL, on an accepted beat, with fb=sig[WIDTH-1], set next[0]=fb^din[0] and next[k]=sig[k-1]^(POLY[k]&fb)^(k<NIN ? din[k] : 0).
REQ-022 SHALL hold sig when no beat is accepted.
REQ-023 SHALL move RUN->DONE on the beat accepted while cnt==1; sig is final in the same cycle that done rises.
REQ-024 SHALL keep sig stable throughout DONE.
REQ-025 SHALL show each beat's update in sig one cycle after acceptance, with no pipeline latency beyond that.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set state=IDLE, sig=0, cnt=0, in_ready=0, busy=0, done=0 (and pass=0 when present).
REQ-027 SHALL give rst priority over start and in_valid; a reset mid-RUN abandons the run with no done.

Configuration
REQ-028 SHALL use macro MISR_ENGINE_CMP_EN to include the golden-signature compare.
REQ-029 SHALL, with MISR_ENGINE_CMP_EN defined, add port golden  in  WIDTH and port pass  out  1, where pass = (state==DONE) && (sig==golden), and pass is 0 in every other state.
REQ-030 SHALL, without MISR_ENGINE_CMP_EN, omit golden, pass and the comparator entirely.

Structure
REQ-031 SHALL place the state enum typedef and its encodings in shared package misr_pkg.
REQ-032 SHALL implement the register and its next-value logic in sub-module misr_core (ports clk, rst, load, seed, en, din, q); the FSM and counter stay in misr_engine.

Verification
REQ-033 SHALL cover: WIDTH=4, POLY=4'b0011, NIN=1, SEED=0, len=5, din=1,0,0,0,0 -> sig 0001,0010,0100,1000,0011; done rises with 0011.
REQ-034 SHALL cover: len=0, start -> done=1 next cycle, sig=SEED, in_ready never high.
REQ-035 SHALL cover: len=3 with in_valid low on alternate cycles -> exactly 3 accepted beats, cnt does not decrement during gaps, sig holds during gaps.
REQ-036 SHALL cover: rst asserted after 2 of 5 beats -> next cycle state IDLE, sig=0, busy=0, done=0; start on the cycle after still works.
REQ-037 SHALL cover: start pulsed in RUN -> ignored, run completes normally; start in DONE -> sig=SEED, new run begins.
REQ-038 SHALL cover: CMP_EN build, golden=4'b0011 with REQ-033 stimulus -> pass=1 in DONE; golden=4'b0000 -> pass=0; pass=0 throughout RUN.
